// File: rtl/t_counter_sync.sv
// Synchronous modulo-MOD counter built from per-bit toggle enables (next q = q ^ t).
// Define T_COUNTER_UPDOWN_EN to add the `up` port and down-counting; otherwise it only counts up.
module t_counter_sync #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(9)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef T_COUNTER_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] t_inc;
  logic [WIDTH-1:0] din_clamp;
  logic             inc_carry;
  logic             at_top;

  // Increment toggles: bit i flips when every lower bit is 1.
  always_comb begin
    t_inc     = '0;
    inc_carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_inc[i]  = inc_carry;
      inc_carry = inc_carry & q_q[i];
    end
  end

`ifdef T_COUNTER_UPDOWN_EN
  logic [WIDTH-1:0] t_dec;
  logic             dec_borrow;

  // Decrement toggles: bit i flips when every lower bit is 0.
  always_comb begin
    t_dec      = '0;
    dec_borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_dec[i]   = dec_borrow;
      dec_borrow = dec_borrow & ~q_q[i];
    end
  end
`endif

  assign din_clamp = (din > MOD) ? MOD : din;
  // Out-of-range states are treated as terminal when counting up.
  assign at_top    = (q_q >= MOD);

  always_comb begin
    t  = '0;
    tc = (q_q == MOD);
`ifdef T_COUNTER_UPDOWN_EN
    if (!up) begin
      tc = (q_q == '0);
    end
`endif
    if (load) begin
      t = q_q ^ din_clamp;
    end else if (en) begin
`ifdef T_COUNTER_UPDOWN_EN
      if (!up) begin
        t = (q_q == '0) ? MOD : t_dec;
      end else
`endif
      begin
        t = at_top ? q_q : t_inc;
      end
    end
  end

  always_comb begin
    q_d    = q_q ^ t;
    wrap_d = en & ~load & tc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_t_counter_sync.sv
// Self-checking bench for t_counter_sync: directed scenarios plus randomized traffic vs. a modulo-counter model.
module tb_t_counter_sync;

  localparam int WIDTH = 4;
  localparam int MOD   = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             tc;
  logic             wrap;

  int checks = 0;
  int passes = 0;
  int m_q;
  int m_wrap;

  always #5 clk = ~clk;

  t_counter_sync #(.WIDTH(WIDTH), .MOD(4'(MOD))) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .load (load),
    .din  (din),
`ifdef T_COUNTER_UPDOWN_EN
    .up   (up),
`endif
    .q    (q),
    .t    (t),
    .tc   (tc),
    .wrap (wrap)
  );

  // Next count as plain modulo arithmetic.
  function automatic int model_next(int cur, bit l, bit e, int d, bit u);
    if (l) return (d > MOD) ? MOD : d;
    if (!e) return cur;
    if (u) return (cur >= MOD) ? 0 : cur + 1;
    return (cur == 0) ? MOD : cur - 1;
  endfunction

  function automatic int model_tc(int cur, bit u);
    if (u) return (cur == MOD) ? 1 : 0;
    return (cur == 0) ? 1 : 0;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic compareAll();
    checkOutput("q", int'(q), m_q);
    checkOutput("wrap", int'(wrap), m_wrap);
    checkOutput("tc", int'(tc), model_tc(m_q, up));
    checkOutput("t", int'(t), model_next(m_q, load, en, int'(din), up) ^ m_q);
  endtask

  // Drive inputs on the falling edge, then check combinational and registered outputs.
  task automatic applyStimulus(bit e, bit l, int d, bit u);
    @(negedge clk);
    en   = e;
    load = l;
    din  = 4'(d);
`ifdef T_COUNTER_UPDOWN_EN
    up   = u;
`else
    up   = 1'b1;
    if (u) begin end
`endif
    #1 compareAll();
  endtask

  task automatic advance();
    @(posedge clk);
    m_wrap = (en && !load) ? model_tc(m_q, up) : 0;
    m_q    = model_next(m_q, load, en, int'(din), up);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; din = '0; up = 1'b1;
    m_q = 0; m_wrap = 0;
    #12;
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_wrap", int'(wrap), 0);
    checkOutput("reset_tc", int'(tc), 0);
    @(negedge clk);
    reset = 1'b1;

    // Full cycle 0..9,0
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 0, 1);
      advance();
    end
    applyStimulus(1, 0, 0, 1);
    checkOutput("pin_q9", int'(q), 9);
    checkOutput("pin_t9", int'(t), 4'b1001);
    checkOutput("pin_tc9", int'(tc), 1);
    advance();
    applyStimulus(1, 0, 0, 1);
    checkOutput("pin_wrap0", int'(q), 0);
    checkOutput("pin_wrap", int'(wrap), 1);
    advance();
    applyStimulus(1, 0, 0, 1);
    checkOutput("pin_wrap_one_cycle", int'(wrap), 0);
    advance();

    // Gated enable from q=3
    for (int k = 0; k < 20 && m_q != 3; k++) begin
      applyStimulus(1, 0, 0, 1);
      advance();
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(k % 2, 0, 0, 1);
      if (k % 2 == 0) checkOutput("pin_hold_t", int'(t), 0);
      advance();
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("pin_after_gated", int'(q), 6);

    // Load with clamp
    for (int k = 0; k < 20 && m_q != 2; k++) begin
      applyStimulus(1, 0, 0, 1);
      advance();
    end
    applyStimulus(1, 1, 7, 1);
    checkOutput("pin_load_t", int'(t), 4'b0101);
    advance();
    applyStimulus(1, 1, 14, 1);
    checkOutput("pin_load_q", int'(q), 7);
    checkOutput("pin_load_wrap", int'(wrap), 0);
    advance();
    applyStimulus(1, 1, 4, 1);
    checkOutput("pin_clamp_q", int'(q), 9);
    checkOutput("pin_clamp_tc", int'(tc), 1);
    advance();
    applyStimulus(0, 0, 0, 1);
    checkOutput("pin_load_over_tc_q", int'(q), 4);
    checkOutput("pin_load_over_tc_wrap", int'(wrap), 0);
    advance();

    // Asynchronous reset in mid-cycle at q=6
    for (int k = 0; k < 20 && m_q != 6; k++) begin
      applyStimulus(1, 0, 0, 1);
      advance();
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("pin_async_q", int'(q), 0);
    checkOutput("pin_async_wrap", int'(wrap), 0);
    m_q = 0; m_wrap = 0;
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 1);
      checkOutput("pin_resume", int'(q), k);
      advance();
    end

`ifdef T_COUNTER_UPDOWN_EN
    applyStimulus(0, 1, 1, 1);
    advance();
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_dn_q1", int'(q), 1);
    advance();
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_dn_q0", int'(q), 0);
    checkOutput("pin_dn_tc", int'(tc), 1);
    checkOutput("pin_dn_t", int'(t), 9);
    advance();
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_dn_q9", int'(q), 9);
    checkOutput("pin_dn_wrap", int'(wrap), 1);
    advance();
    applyStimulus(1, 0, 0, 0);
    checkOutput("pin_dn_q8", int'(q), 8);
    advance();
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      advance();
    end
    applyStimulus(0, 0, 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/t_counter_sync.md
# t_counter_sync

Synchronous modulo-MOD counter built on toggle-stage semantics: it computes the per-bit toggle-enable vector that drives a bank of T flip-flop stages and holds that bank internally, so every bit changes on the same clock edge. It sits directly upstream of the T flip-flop stages: the toggle vector `t` is exported so single-stage toggle flops can be checked bit-for-bit against it. Used as the counting/divider stage in the sequential-logic set.

## Interface
- `WIDTH`, 4, number of counter bits / toggle stages (≥ 2).
- `MOD`, 4'd9, terminal count; sequence is 0..MOD (MOD ≤ 2^WIDTH−1).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `en`  input  1  count enable; one step per cycle while high.
- `load`  input  1  synchronous load of `din`; overrides `en`.
- `din`  input  WIDTH  load value.
- `up`  input  1  direction, 1 = up, 0 = down (present only with `T_COUNTER_UPDOWN_EN`).
- `q`  output  WIDTH  registered count.
- `t`  output  WIDTH  combinational toggle vector; next `q` = `q ^ t`.
- `tc`  output  1  combinational terminal-count flag.
- `wrap`  output  1  registered one-cycle pulse after a wrap step.

## Operation
- Single state register `q` plus `wrap` flop; next `q` is always `q ^ t`, so `t` is the only next-state path.
- Priority per cycle: `load` > `en` > hold.
- Hold (`load`=0, `en`=0): `t` = 0.
- Load: `t` = `q ^ din'`, where `din'` = `din` if `din` ≤ MOD, else MOD (clamp). Load never asserts `wrap`.
- Count up, `q` < MOD: `t[0]` = 1, `t[i]` = AND of `q[i-1:0]` (binary increment as toggles).
- Count up, `q` = MOD: `t` = `q` (next `q` = 0); wrap step.
- Count down, `q` > 0: `t[0]` = 1, `t[i]` = NOR of `q[i-1:0]`.
- Count down, `q` = 0: `t` = MOD (next `q` = MOD); wrap step.
- `q` > MOD is unreachable from reset or load; if forced, up-count treats it as ≥ MOD and wraps to 0.
- `tc` = (up & `q`==MOD) | (down & `q`==0), independent of `en`.
- `wrap` ← (`en` & ~`load` & `tc`) each edge.
- Arithmetic is unsigned WIDTH-bit; no carry out beyond `wrap`.

## Timing
- Reset (`reset` low): `q` = 0, `wrap` = 0 immediately, no clock needed; `t` and `tc` follow from `q` = 0 (up: `t` = {0..,en}, `tc` = 0; down: `tc` = 1).
- Reset release: first count on the first rising edge with `reset` high and `en` high.
- Reset asserted mid-count: clears at once, and the in-flight step is discarded.
- Latency: `q` updates one edge after `en`/`load` sampled; `wrap` is high for exactly the cycle following the wrap edge.
- `t`/`tc` are combinational from `q`, `en`, `load`, `din`, `up`; valid before each edge.
- Simultaneous `load` and `en`: load wins, and no wrap occurs even if `tc`.
- Direction change takes effect the same cycle `up` changes.

## Configuration
- `T_COUNTER_UPDOWN_EN` defined: `up` port exists, and both directions are supported as above.
- Undefined: `up` port removed, direction hard-wired up, and down-count logic not built.

## Test plan
- Reset then `en`=1, WIDTH=4, MOD=9: `q` 0,1,…,9,0; `wrap` high one cycle after the 9→0 edge only; `t` = 4'b1001 while `q`=9.
- `en` toggled every other cycle from `q`=3: `q` holds when `en`=0, `t`=0 on hold cycles, and no skipped or double steps.
- `load`=1, `din`=7 with `en`=1 at `q`=2: next `q`=7, `t`=4'b0101, `wrap`=0; `din`=14 clamps to 9.
- `load`+`en` at `q`=9 (`tc`=1): `q` = `din`, `wrap` stays 0.
- `reset` pulled low mid-cycle at `q`=6: `q`=0 before the next edge; after release, counting resumes 0,1,2.
- With `T_COUNTER_UPDOWN_EN`, `up`=0 from `q`=1: `q` 1,0,9,8; `tc`=1 at `q`=0; `wrap` pulses after the 0→9 edge.
